// File: rtl/decode_pkg.sv
// Shared opcode encodings and one-hot type bit positions for the instruction
// type decode stage.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int unsigned TYPE_W = 10;

  localparam int unsigned T_R      = 0;
  localparam int unsigned T_I      = 1;
  localparam int unsigned T_STORE  = 2;
  localparam int unsigned T_LOAD   = 3;
  localparam int unsigned T_BRANCH = 4;
  localparam int unsigned T_JAL    = 5;
  localparam int unsigned T_JALR   = 6;
  localparam int unsigned T_LUI    = 7;
  localparam int unsigned T_AUIPC  = 8;
  localparam int unsigned T_SYSTEM = 9;

endpackage

// File: rtl/opcode_classify.sv
// Combinational single-lane opcode classifier: one-hot type plus illegal flag.
// A disabled lane reports neither a type nor an illegal opcode.
module opcode_classify
  import decode_pkg::*;
(
  input  logic [6:0]        opcode_i,
  input  logic              lane_en_i,
  output logic [TYPE_W-1:0] type_o,
  output logic              illegal_o
);

  logic [TYPE_W-1:0] type_raw;

  always_comb begin
    type_raw = '0;
    case (opcode_i)
      OP_R:      type_raw[T_R]      = 1'b1;
      OP_I:      type_raw[T_I]      = 1'b1;
      OP_STORE:  type_raw[T_STORE]  = 1'b1;
      OP_LOAD:   type_raw[T_LOAD]   = 1'b1;
      OP_BRANCH: type_raw[T_BRANCH] = 1'b1;
      OP_JAL:    type_raw[T_JAL]    = 1'b1;
      OP_JALR:   type_raw[T_JALR]   = 1'b1;
      OP_LUI:    type_raw[T_LUI]    = 1'b1;
      OP_AUIPC:  type_raw[T_AUIPC]  = 1'b1;
      OP_SYSTEM: type_raw[T_SYSTEM] = 1'b1;
      default:   type_raw = '0;
    endcase
  end

  assign type_o    = lane_en_i ? type_raw : '0;
  assign illegal_o = lane_en_i && (type_raw == '0);

endmodule

// File: rtl/instr_type_decode_stage.sv
// Registered multi-lane instruction type decoder with valid/ready handshake and
// first-error capture. Define DECODE_PERF_CNT_EN to build per-type counters.
module instr_type_decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*32-1:0]       in_instr,
  input  logic [LANES-1:0]          in_lane_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*TYPE_W-1:0]   out_type,
  output logic [LANES-1:0]          out_illegal,
  output logic [LANES-1:0]          out_lane_en,
  output logic                      err_sticky,
  output logic [1:0]                err_lane,
  output logic [31:0]               err_instr,
  input  logic                      err_clr,
  input  logic [3:0]                cnt_sel,
  output logic [CNT_W-1:0]          cnt_val
);

  logic [LANES*TYPE_W-1:0] type_d, type_q;
  logic [LANES-1:0]        ill_d, ill_q;
  logic [LANES-1:0]        lane_en_q;
  logic                    valid_q;
  logic                    sticky_q;
  logic [1:0]              err_lane_q;
  logic [31:0]             err_instr_q;
  logic                    accept;
  logic                    ill_found;
  logic [1:0]              ill_lane;
  logic [31:0]             ill_instr;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    opcode_classify u_classify (
      .opcode_i  (in_instr[32*k +: 7]),
      .lane_en_i (in_lane_en[k]),
      .type_o    (type_d[TYPE_W*k +: TYPE_W]),
      .illegal_o (ill_d[k])
    );
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Lowest-index illegal lane wins: scan downward so lane 0 is assigned last.
  always_comb begin
    ill_found = 1'b0;
    ill_lane  = '0;
    ill_instr = '0;
    for (int unsigned k = LANES; k > 0; k--) begin
      if (ill_d[k-1]) begin
        ill_found = 1'b1;
        ill_lane  = 2'(k-1);
        ill_instr = in_instr[32*(k-1) +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      type_q    <= '0;
      ill_q     <= '0;
      lane_en_q <= '0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      type_q    <= type_d;
      ill_q     <= ill_d;
      lane_en_q <= in_lane_en;
    end else if (out_ready) begin
      valid_q   <= 1'b0;
    end
  end

  // A fresh capture takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q    <= 1'b0;
      err_lane_q  <= '0;
      err_instr_q <= '0;
    end else if (accept && ill_found && (!sticky_q || err_clr)) begin
      sticky_q    <= 1'b1;
      err_lane_q  <= ill_lane;
      err_instr_q <= ill_instr;
    end else if (err_clr) begin
      sticky_q    <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_type    = type_q;
  assign out_illegal = ill_q;
  assign out_lane_en = lane_en_q;
  assign err_sticky  = sticky_q;
  assign err_lane    = err_lane_q;
  assign err_instr   = err_instr_q;

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q [TYPE_W];
  logic [CNT_W-1:0] cnt_d [TYPE_W];

  always_comb begin
    for (int unsigned t = 0; t < TYPE_W; t++) begin
      logic [CNT_W+2:0] sum;
      sum = {3'b000, cnt_q[t]};
      if (accept) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          sum = sum + {{(CNT_W+2){1'b0}}, type_d[TYPE_W*k + t]};
        end
      end
      cnt_d[t] = (sum[CNT_W+2:CNT_W] != 3'b000) ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned t = 0; t < TYPE_W; t++) cnt_q[t] <= '0;
    end else begin
      for (int unsigned t = 0; t < TYPE_W; t++) cnt_q[t] <= cnt_d[t];
    end
  end

  always_comb begin
    cnt_val = '0;
    for (int unsigned t = 0; t < TYPE_W; t++) begin
      if (cnt_sel == 4'(t)) cnt_val = cnt_q[t];
    end
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_val        = '0;
`endif

endmodule

// File: tb/tb_instr_type_decode_stage.sv
// Directed self-checking bench for instr_type_decode_stage (LANES=2, CNT_W=4).
module tb_instr_type_decode_stage;

  localparam int unsigned LANES = 2;
  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_instr;
  logic [1:0]        in_lane_en;
  logic              out_valid;
  logic              out_ready;
  logic [19:0]       out_type;
  logic [1:0]        out_illegal;
  logic [1:0]        out_lane_en;
  logic              err_sticky;
  logic [1:0]        err_lane;
  logic [31:0]       err_instr;
  logic              err_clr;
  logic [3:0]        cnt_sel;
  logic [CNT_W-1:0]  cnt_val;

  int n_cmp = 0;
  int n_fail = 0;

  instr_type_decode_stage #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lane_en(in_lane_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_type(out_type), .out_illegal(out_illegal),
    .out_lane_en(out_lane_en), .err_sticky(err_sticky), .err_lane(err_lane),
    .err_instr(err_instr), .err_clr(err_clr), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_lane_en = '0;
    out_ready = 1'b1; err_clr = 1'b0; cnt_sel = 4'd1;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_type !== 20'h0 || out_illegal !== 2'b00 || out_lane_en !== 2'b00) begin
      n_fail++; $display("FAIL reset_out got type=%h ill=%b en=%b exp 0", out_type, out_illegal, out_lane_en); end
    n_cmp++; if (err_sticky !== 1'b0 || err_lane !== 2'd0 || err_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_err got st=%b ln=%0d ins=%h exp 0", err_sticky, err_lane, err_instr); end
    n_cmp++; if (cnt_val !== 4'h0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", cnt_val); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_legal_pair();
    in_valid = 1'b1; in_lane_en = 2'b11;
    in_instr = {32'h00000013, 32'h002081B3};
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pair_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_type !== 20'h00801) begin n_fail++; $display("FAIL pair_type got=%h exp=00801", out_type); end
    n_cmp++; if (out_illegal !== 2'b00) begin n_fail++; $display("FAIL pair_ill got=%b exp=00", out_illegal); end
    n_cmp++; if (out_lane_en !== 2'b11) begin n_fail++; $display("FAIL pair_en got=%b exp=11", out_lane_en); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pair_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_lane_en = 2'b11;
    in_instr = {32'h0000006F, 32'h000000B7};
    step();
    in_instr = {32'h00000063, 32'h00002023};
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_type !== 20'h08080) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b type=%h exp v=1 type=08080", i, out_valid, out_type); end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_type !== 20'h04004) begin
      n_fail++; $display("FAIL bp_nobubble got v=%b type=%h exp v=1 type=04004", out_valid, out_type); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_lane_en = 2'b11;
    in_instr = {32'h00000017, 32'h00000067};
    step();
    n_cmp++; if (out_type !== 20'h40040) begin n_fail++; $display("FAIL b2b_first got=%h exp=40040", out_type); end
    in_instr = {32'h00000073, 32'h00000003};
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_type !== 20'h80008) begin
      n_fail++; $display("FAIL b2b_second got v=%b type=%h exp v=1 type=80008", out_valid, out_type); end
    step();
  endtask

  task automatic test_illegal_capture();
    in_valid = 1'b1; in_lane_en = 2'b11;
    in_instr = {32'hFFFFFFFF, 32'h00000000};
    step();
    n_cmp++; if (out_illegal !== 2'b11 || out_type !== 20'h0) begin
      n_fail++; $display("FAIL ill_out got ill=%b type=%h exp ill=11 type=0", out_illegal, out_type); end
    n_cmp++; if (err_sticky !== 1'b1 || err_lane !== 2'd0 || err_instr !== 32'h00000000) begin
      n_fail++; $display("FAIL ill_capture got st=%b ln=%0d ins=%h exp st=1 ln=0 ins=00000000", err_sticky, err_lane, err_instr); end
    in_instr = {32'h0000000B, 32'h00000013};
    step();
    n_cmp++; if (out_illegal !== 2'b10) begin n_fail++; $display("FAIL ill_second_out got=%b exp=10", out_illegal); end
    n_cmp++; if (err_sticky !== 1'b1 || err_lane !== 2'd0 || err_instr !== 32'h00000000) begin
      n_fail++; $display("FAIL ill_hold got st=%b ln=%0d ins=%h exp st=1 ln=0 ins=00000000", err_sticky, err_lane, err_instr); end
    err_clr = 1'b1;
    in_instr = {32'h0000007F, 32'h00000013};
    step();
    in_valid = 1'b0;
    n_cmp++; if (err_sticky !== 1'b1 || err_lane !== 2'd1 || err_instr !== 32'h0000007F) begin
      n_fail++; $display("FAIL ill_clr_recap got st=%b ln=%0d ins=%h exp st=1 ln=1 ins=0000007f", err_sticky, err_lane, err_instr); end
    step();
    err_clr = 1'b0;
    n_cmp++; if (err_sticky !== 1'b0 || err_lane !== 2'd1 || err_instr !== 32'h0000007F) begin
      n_fail++; $display("FAIL ill_clr_only got st=%b ln=%0d ins=%h exp st=0 ln=1 ins=0000007f", err_sticky, err_lane, err_instr); end
  endtask

  task automatic test_disabled_lane();
    in_valid = 1'b1; in_lane_en = 2'b01;
    in_instr = {32'h00000000, 32'h00000013};
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_illegal !== 2'b00 || out_type !== 20'h00002 || out_lane_en !== 2'b01) begin
      n_fail++; $display("FAIL dis_lane got ill=%b type=%h en=%b exp ill=00 type=00002 en=01", out_illegal, out_type, out_lane_en); end
    n_cmp++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL dis_err got=%b exp=0", err_sticky); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_lane_en = 2'b11;
    in_instr = {32'h00000000, 32'h00000013};
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got v=%b st=%b exp v=1 st=1", out_valid, err_sticky); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_sticky !== 1'b0 || cnt_val !== 4'h0) begin
      n_fail++; $display("FAIL mid_rst got v=%b rdy=%b st=%b cnt=%h exp v=0 rdy=1 st=0 cnt=0", out_valid, in_ready, err_sticky, cnt_val); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_noreplay got=%b exp=0", out_valid); end
  endtask

  task automatic test_counters();
    in_valid = 1'b1; in_lane_en = 2'b11; out_ready = 1'b1;
    in_instr = {32'h00000013, 32'h00000013};
    cnt_sel = 4'd1;
    for (int i = 0; i < 7; i++) step();
`ifdef DECODE_PERF_CNT_EN
    n_cmp++; if (cnt_val !== 4'hE) begin n_fail++; $display("FAIL cnt_partial got=%h exp=e", cnt_val); end
`else
    n_cmp++; if (cnt_val !== 4'h0) begin n_fail++; $display("FAIL cnt_off got=%h exp=0", cnt_val); end
`endif
    for (int i = 0; i < 11; i++) step();
    in_valid = 1'b0;
`ifdef DECODE_PERF_CNT_EN
    n_cmp++; if (cnt_val !== 4'hF) begin n_fail++; $display("FAIL cnt_sat got=%h exp=f", cnt_val); end
`else
    n_cmp++; if (cnt_val !== 4'h0) begin n_fail++; $display("FAIL cnt_off_end got=%h exp=0", cnt_val); end
`endif
    cnt_sel = 4'd12;
    #1;
    n_cmp++; if (cnt_val !== 4'h0) begin n_fail++; $display("FAIL cnt_sel_oob got=%h exp=0", cnt_val); end
    cnt_sel = 4'd0;
    #1;
    n_cmp++; if (cnt_val !== 4'h0) begin n_fail++; $display("FAIL cnt_r_type got=%h exp=0", cnt_val); end
    step();
  endtask

  initial begin
    test_reset();
    test_legal_pair();
    test_backpressure();
    test_back_to_back();
    test_illegal_capture();
    test_disabled_lane();
    test_reset_mid();
    test_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
